// File: rtl/line_span_writer.sv
// Breaks horizontal spans into masked 4-pixel line buffer word writes (optional SPAN_TRANSPARENCY_EN drops colour-0 spans).
// First write one cycle after acceptance, one word per cycle; span_ready low while busy; line_start aborts.
module line_span_writer #(
  parameter int COLOR_W    = 8,
  parameter int LINE_WORDS = 160
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_start,
  input  logic                 span_valid,
  output logic                 span_ready,
  input  logic [9:0]           span_x,
  input  logic [9:0]           span_len,
  input  logic [COLOR_W-1:0]   span_color,
  output logic                 write_pixel,
  output logic [7:0]           pixel_addr,
  output logic [3:0]           pixel_write_updated,
  output logic [4*COLOR_W-1:0] pixel_wdata,
  output logic                 span_done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [10:0] LINE_PIX = 11'(4 * LINE_WORDS);
  localparam logic [10:0] LAST_PIX = 11'(4 * LINE_WORDS - 1);

  state_t state, state_nx;

  logic [7:0]  w1_q;
  logic [1:0]  xe_q;

  logic [10:0] x_sum;
  logic [9:0]  x_end;
  logic [7:0]  w0_in, w1_in;
  logic        drop_in;
  logic [7:0]  addr_inc;

  logic                 rdy_nx, wr_nx, done_nx, latch;
  logic [7:0]           addr_nx;
  logic [3:0]           mask_nx;
  logic [4*COLOR_W-1:0] wdata_nx;

  function automatic logic [3:0] word_mask(input logic first, input logic last,
                                           input logic [1:0] lo, input logic [1:0] hi);
    logic [3:0] m;
    m = 4'hF;
    if (first) m = m & (4'hF << lo);
    if (last)  m = m & (4'hF >> (2'd3 - hi));
    return m;
  endfunction

  // 11-bit sum so a span running past the line end clips instead of wrapping.
  always_comb begin
    x_sum   = {1'b0, span_x} + {1'b0, span_len} - 11'd1;
    x_end   = (x_sum > LAST_PIX) ? LAST_PIX[9:0] : x_sum[9:0];
    w0_in   = span_x[9:2];
    w1_in   = x_end[9:2];
    drop_in = (span_len == '0) || ({1'b0, span_x} >= LINE_PIX);
`ifdef SPAN_TRANSPARENCY_EN
    drop_in = drop_in || (span_color == '0);
`else
    drop_in = drop_in;
`endif
    addr_inc = pixel_addr + 8'd1;
  end

  always_comb begin
    state_nx = state;
    rdy_nx   = 1'b0;
    wr_nx    = 1'b0;
    done_nx  = 1'b0;
    latch    = 1'b0;
    addr_nx  = pixel_addr;
    mask_nx  = 4'h0;
    wdata_nx = pixel_wdata;
    case (state)
      IDLE: begin
        if (span_valid && span_ready) begin
          latch = 1'b1;
          if (drop_in) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = WRITE;
            wr_nx    = 1'b1;
            addr_nx  = w0_in;
            mask_nx  = word_mask(1'b1, w0_in == w1_in, span_x[1:0], x_end[1:0]);
            wdata_nx = {4{span_color}};
          end
        end else begin
          rdy_nx = 1'b1;
        end
      end
      WRITE: begin
        if (pixel_addr == w1_q) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          wr_nx   = 1'b1;
          addr_nx = addr_inc;
          mask_nx = word_mask(1'b0, addr_inc == w1_q, 2'd0, xe_q);
        end
      end
      DONE: begin
        state_nx = IDLE;
        rdy_nx   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // line_start wins over everything, including a same-cycle acceptance.
    if (line_start) begin
      state_nx = IDLE;
      rdy_nx   = 1'b0;
      wr_nx    = 1'b0;
      done_nx  = 1'b0;
      mask_nx  = 4'h0;
      latch    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      span_ready          <= 1'b0;
      write_pixel         <= 1'b0;
      pixel_addr          <= '0;
      pixel_write_updated <= '0;
      pixel_wdata         <= '0;
      span_done           <= 1'b0;
      w1_q                <= '0;
      xe_q                <= '0;
    end else begin
      state               <= state_nx;
      span_ready          <= rdy_nx;
      write_pixel         <= wr_nx;
      pixel_addr          <= addr_nx;
      pixel_write_updated <= mask_nx;
      pixel_wdata         <= wdata_nx;
      span_done           <= done_nx;
      if (latch) begin
        w1_q <= w1_in;
        xe_q <= x_end[1:0];
      end
    end
  end

endmodule
